rv32i_decode_stage: RTL and testbench

// - Registered RV32I decode stage. It is the producer side of the ALU control interface and sits between fetch and execute.
// - Accepts one 32-bit instruction plus its PC per valid/ready handshake.
// - Emits per instruction: the 5-bit ALU_control code, register addresses, immediate, operand selects and datapath control.
// - Output register is one entry deep with full backpressure and a synchronous flush.

---
 rtl/rv32i_pkg.sv | 85 ++++++++
 rtl/rv32i_imm_gen.sv | 33 +++
 rtl/rv32i_decode_stage.sv | 210 +++++++++++++++++++++
 tb/tb_rv32i_decode_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: ALU_control codes, opcodes, funct7 values and the
// decoded control bundle carried by the decode stage output register.
package rv32i_pkg;

    localparam logic [4:0] ALU_NOP  = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_XOR  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_AND  = 5'd5;
    localparam logic [4:0] ALU_SLL  = 5'd6;
    localparam logic [4:0] ALU_SRL  = 5'd7;
    localparam logic [4:0] ALU_SRA  = 5'd8;
    localparam logic [4:0] ALU_SLT  = 5'd9;
    localparam logic [4:0] ALU_SLTU = 5'd10;
    localparam logic [4:0] ALU_BEQ  = 5'd11;
    localparam logic [4:0] ALU_BNE  = 5'd12;
    localparam logic [4:0] ALU_BLT  = 5'd13;
    localparam logic [4:0] ALU_BGE  = 5'd14;
    localparam logic [4:0] ALU_BLTU = 5'd15;
    localparam logic [4:0] ALU_BGEU = 5'd16;
    localparam logic [4:0] ALU_JAL  = 5'd17;
    localparam logic [4:0] ALU_LUI  = 5'd18;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [4:0] alu_control;
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [4:0] rd_addr;
        logic       alu_src_imm;
        logic       alu_src_pc;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       illegal;
        logic [2:0] mem_size;
    } decode_ctrl_t;

    // Base-encoding ALU op shared by OP and OP-IMM (funct7 handled by caller)
    function automatic logic [4:0] alu_from_funct3(input logic [2:0] funct3);
        logic [4:0] code;
        case (funct3)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = ALU_SRL;
            3'b110:  code = ALU_OR;
            3'b111:  code = ALU_AND;
            default: code = ALU_NOP;
        endcase
        return code;
    endfunction

    function automatic logic [4:0] branch_alu(input logic [2:0] funct3);
        logic [4:0] code;
        case (funct3)
            3'b000:  code = ALU_BEQ;
            3'b001:  code = ALU_BNE;
            3'b100:  code = ALU_BLT;
            3'b101:  code = ALU_BGE;
            3'b110:  code = ALU_BLTU;
            3'b111:  code = ALU_BGEU;
            default: code = ALU_NOP;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational immediate generator. LUI is left unshifted because the ALU
// applies the <<12 itself; shift-immediates yield only the shift amount.
module rv32i_imm_gen
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    // Select the immediate format from the opcode
    always_comb begin
        imm = '0;
        case (instr[6:0])
            OPC_OP_IMM: begin
                if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101) begin
                    imm = XLEN'(instr[24:20]);
                end else begin
                    imm = XLEN'($signed(instr[31:20]));
                end
            end
            OPC_LOAD, OPC_JALR: imm = XLEN'($signed(instr[31:20]));
            OPC_STORE:  imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            OPC_BRANCH: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            OPC_JAL:    imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            OPC_LUI:    imm = XLEN'(instr[31:12]);
            OPC_AUIPC:  imm = XLEN'($signed({instr[31:12], 12'h000}));
            default:    imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_decode_stage.sv
// Registered RV32I decode stage: one-deep output register with valid/ready
// backpressure and synchronous flush, feeding the ALU control interface.
module rv32i_decode_stage
    import rv32i_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      alu_control,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] imm,
    output logic            alu_src_imm,
    output logic            alu_src_pc,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            jump,
    output logic            illegal,
    output logic [2:0]      mem_size,
    output logic [XLEN-1:0] pc_out
);

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic            legal_s;
    logic            in_ready_s;
    logic            accept_s;
    decode_ctrl_t    ctrl_s;
    logic [XLEN-1:0] imm_s;

    logic            valid_r;
    decode_ctrl_t    ctrl_r;
    logic [XLEN-1:0] imm_r;
    logic [XLEN-1:0] pc_r;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];

    rv32i_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (instr),
        .imm   (imm_s)
    );

    // Decode the incoming instruction into the control bundle
    always_comb begin
        ctrl_s          = '0;
        legal_s         = 1'b0;
        ctrl_s.rs1_addr = instr[19:15];
        ctrl_s.rs2_addr = instr[24:20];
        ctrl_s.rd_addr  = instr[11:7];
        case (opcode_s)
            OPC_OP: begin
                ctrl_s.reg_write = 1'b1;
                if (funct7_s == F7_BASE) begin
                    ctrl_s.alu_control = alu_from_funct3(funct3_s);
                    legal_s            = 1'b1;
                end else if (funct7_s == F7_ALT && funct3_s == 3'b000) begin
                    ctrl_s.alu_control = ALU_SUB;
                    legal_s            = 1'b1;
                end else if (funct7_s == F7_ALT && funct3_s == 3'b101) begin
                    ctrl_s.alu_control = ALU_SRA;
                    legal_s            = 1'b1;
                end else begin
                    legal_s = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                ctrl_s.reg_write   = 1'b1;
                ctrl_s.alu_src_imm = 1'b1;
                if (funct3_s == 3'b001) begin
                    ctrl_s.alu_control = ALU_SLL;
                    legal_s            = (funct7_s == F7_BASE);
                end else if (funct3_s == 3'b101) begin
                    if (funct7_s == F7_BASE) begin
                        ctrl_s.alu_control = ALU_SRL;
                        legal_s            = 1'b1;
                    end else if (funct7_s == F7_ALT) begin
                        ctrl_s.alu_control = ALU_SRA;
                        legal_s            = 1'b1;
                    end else begin
                        legal_s = 1'b0;
                    end
                end else begin
                    ctrl_s.alu_control = alu_from_funct3(funct3_s);
                    legal_s            = 1'b1;
                end
            end
            OPC_LOAD: begin
                ctrl_s.alu_control = ALU_ADD;
                ctrl_s.alu_src_imm = 1'b1;
                ctrl_s.mem_read    = 1'b1;
                ctrl_s.reg_write   = 1'b1;
                ctrl_s.mem_size    = funct3_s;
                legal_s            = (funct3_s != 3'b011) && (funct3_s[2:1] != 2'b11);
            end
            OPC_STORE: begin
                ctrl_s.alu_control = ALU_ADD;
                ctrl_s.alu_src_imm = 1'b1;
                ctrl_s.mem_write   = 1'b1;
                ctrl_s.mem_size    = funct3_s;
                legal_s            = (funct3_s[2] == 1'b0) && (funct3_s != 3'b011);
            end
            OPC_BRANCH: begin
                ctrl_s.alu_control = branch_alu(funct3_s);
                ctrl_s.branch      = 1'b1;
                legal_s            = (funct3_s[2:1] != 2'b01);
            end
            OPC_JAL, OPC_JALR: begin
                ctrl_s.alu_control = ALU_JAL;
                ctrl_s.jump        = 1'b1;
                ctrl_s.alu_src_pc  = 1'b1;
                ctrl_s.reg_write   = 1'b1;
                legal_s            = (opcode_s == OPC_JAL) || (funct3_s == 3'b000);
            end
            OPC_LUI: begin
                ctrl_s.alu_control = ALU_LUI;
                ctrl_s.alu_src_imm = 1'b1;
                ctrl_s.reg_write   = 1'b1;
                legal_s            = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl_s.alu_control = ALU_ADD;
                ctrl_s.alu_src_pc  = 1'b1;
                ctrl_s.alu_src_imm = 1'b1;
                ctrl_s.reg_write   = 1'b1;
                legal_s            = 1'b1;
            end
            default: legal_s = 1'b0;
        endcase

        // Illegal encodings must not leave any side effect for execute
        if (!legal_s) begin
            ctrl_s.alu_control = ALU_NOP;
            ctrl_s.alu_src_imm = 1'b0;
            ctrl_s.alu_src_pc  = 1'b0;
            ctrl_s.reg_write   = 1'b0;
            ctrl_s.mem_read    = 1'b0;
            ctrl_s.mem_write   = 1'b0;
            ctrl_s.branch      = 1'b0;
            ctrl_s.jump        = 1'b0;
            ctrl_s.mem_size    = 3'b000;
            ctrl_s.illegal     = 1'b1;
        end else if (instr[11:7] == 5'd0) begin
            ctrl_s.reg_write = 1'b0;
        end else begin
            ctrl_s.illegal = 1'b0;
        end
    end

    assign in_ready_s = !valid_r || out_ready;
    assign accept_s   = in_valid && in_ready_s && !flush;

    // Output register bank: flush beats accept, accept beats drain, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
            imm_r   <= '0;
            pc_r    <= RESET_PC;
        end else if (flush) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
            imm_r   <= '0;
            pc_r    <= RESET_PC;
        end else if (accept_s) begin
            valid_r <= 1'b1;
            ctrl_r  <= ctrl_s;
            imm_r   <= imm_s;
            pc_r    <= pc_in;
        end else if (valid_r && out_ready) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
            imm_r   <= '0;
            pc_r    <= RESET_PC;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = valid_r;
    assign alu_control = ctrl_r.alu_control;
    assign rs1_addr    = ctrl_r.rs1_addr;
    assign rs2_addr    = ctrl_r.rs2_addr;
    assign rd_addr     = ctrl_r.rd_addr;
    assign imm         = imm_r;
    assign alu_src_imm = ctrl_r.alu_src_imm;
    assign alu_src_pc  = ctrl_r.alu_src_pc;
    assign reg_write   = ctrl_r.reg_write;
    assign mem_read    = ctrl_r.mem_read;
    assign mem_write   = ctrl_r.mem_write;
    assign branch      = ctrl_r.branch;
    assign jump        = ctrl_r.jump;
    assign illegal     = ctrl_r.illegal;
    assign mem_size    = ctrl_r.mem_size;
    assign pc_out      = pc_r;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Scoreboard bench for rv32i_decode_stage: driver pushes reference-model
// bundles on accept, a monitor compares them when the stage presents them.
module tb_rv32i_decode_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0080;

    typedef struct packed {
        logic [4:0]  alu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        src_imm;
        logic        src_pc;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        jmp;
        logic        ill;
        logic [2:0]  msize;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] instr, pc_in, imm, pc_out;
    logic [4:0]  alu_control, rs1_addr, rs2_addr, rd_addr;
    logic        alu_src_imm, alu_src_pc, reg_write, mem_read, mem_write;
    logic        branch, jump, illegal;
    logic [2:0]  mem_size;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    rv32i_decode_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_control(alu_control), .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr), .rd_addr(rd_addr), .imm(imm), .alu_src_imm(alu_src_imm),
        .alu_src_pc(alu_src_pc), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .jump(jump), .illegal(illegal),
        .mem_size(mem_size), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t dut_bundle();
        exp_t a;
        a = '{alu: alu_control, rs1: rs1_addr, rs2: rs2_addr, rd: rd_addr, imm: imm,
              pc: pc_out, src_imm: alu_src_imm, src_pc: alu_src_pc, rw: reg_write,
              mr: mem_read, mw: mem_write, br: branch, jmp: jump, ill: illegal,
              msize: mem_size};
        return a;
    endfunction

    // Reference model written directly from the RV32I encoding rules
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ok;
        logic [4:0] base_ops [8];
        logic [4:0] br_ops   [8];
        base_ops = '{5'd1, 5'd6, 5'd9, 5'd10, 5'd3, 5'd7, 5'd4, 5'd5};
        br_ops   = '{5'd11, 5'd12, 5'd0, 5'd0, 5'd13, 5'd14, 5'd15, 5'd16};
        e = '0;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; ok = 1'b0;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.pc = pc;
        case (op)
            7'h33: begin
                ok    = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.alu = (f7 == 7'h20) ? ((f3 == 3'd0) ? 5'd2 : 5'd8) : base_ops[f3];
                e.rw  = 1'b1;
            end
            7'h13: begin
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
                else ok = 1'b1;
                e.alu = (f3 == 3'd5 && f7 == 7'h20) ? 5'd8 : base_ops[f3];
                e.imm = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins[24:20]} : 32'($signed(ins) >>> 20);
                e.src_imm = 1'b1; e.rw = 1'b1;
            end
            7'h03: begin
                ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
                e.alu = 5'd1; e.src_imm = 1'b1; e.mr = 1'b1; e.rw = 1'b1; e.msize = f3;
                e.imm = 32'($signed(ins) >>> 20);
            end
            7'h23: begin
                ok = (f3 < 3'd3);
                e.alu = 5'd1; e.src_imm = 1'b1; e.mw = 1'b1; e.msize = f3;
                e.imm = 32'(($signed(ins) >>> 25) <<< 5) | {27'd0, ins[11:7]};
            end
            7'h63: begin
                ok = (f3 != 3'd2) && (f3 != 3'd3);
                e.alu = br_ops[f3]; e.br = 1'b1;
                e.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'h6F: begin
                ok = 1'b1; e.alu = 5'd17; e.jmp = 1'b1; e.src_pc = 1'b1; e.rw = 1'b1;
                e.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'h67: begin
                ok = (f3 == 3'd0); e.alu = 5'd17; e.jmp = 1'b1; e.src_pc = 1'b1; e.rw = 1'b1;
                e.imm = 32'($signed(ins) >>> 20);
            end
            7'h37: begin
                ok = 1'b1; e.alu = 5'd18; e.src_imm = 1'b1; e.rw = 1'b1;
                e.imm = ins >> 12;
            end
            7'h17: begin
                ok = 1'b1; e.alu = 5'd1; e.src_pc = 1'b1; e.src_imm = 1'b1; e.rw = 1'b1;
                e.imm = ins & 32'hFFFF_F000;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.alu = 5'd0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0;
            e.jmp = 1'b0; e.src_imm = 1'b0; e.src_pc = 1'b0; e.msize = 3'd0; e.ill = 1'b1;
        end
        if (e.rd == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0:  w[6:0] = 7'h33;
            1:  w[6:0] = 7'h13;
            2:  w[6:0] = 7'h03;
            3:  w[6:0] = 7'h23;
            4:  w[6:0] = 7'h63;
            5:  w[6:0] = 7'h6F;
            6:  w[6:0] = 7'h67;
            7:  w[6:0] = 7'h37;
            8:  w[6:0] = 7'h17;
            9:  w[6:0] = 7'h0F;
            10: w[6:0] = 7'h73;
            default: w[6:0] = w[6:0];
        endcase
        if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    // One cycle of stimulus; the model bundle is queued once the edge has taken it
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        logic exp_rdy, acc;
        @(negedge clk);
        in_valid = iv; instr = ins; pc_in = pc; out_ready = ordy; flush = fl;
        #1;
        exp_rdy = (exp_q.size() == 0) || ordy;
        check("in_ready", in_ready, exp_rdy);
        acc = iv && exp_rdy && !fl;
        @(posedge clk);
        #1;
        if (acc) exp_q.push_back(model(ins, pc));
    endtask

    task automatic directed(input logic [31:0] ins, input logic [31:0] pc, input logic [4:0] alu,
                            input logic [31:0] exp_imm, input logic chk_imm, input logic ill,
                            input logic [14:0] regs, input logic [3:0] flags, input logic [3:0] mask);
        cycle(1'b1, ins, pc, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        #1;
        check("dir_out_valid", out_valid, 1'b1);
        check("dir_alu_control", alu_control, alu);
        check("dir_illegal", illegal, ill);
        check("dir_regs", {rs1_addr, rs2_addr, rd_addr}, regs);
        check("dir_pc_out", pc_out, pc);
        check("dir_flags", {reg_write, alu_src_imm, alu_src_pc, branch} & mask, flags & mask);
        if (chk_imm) check("dir_imm", imm, exp_imm);
    endtask

    // Monitor: compares whatever the stage presents against the scoreboard head
    always @(negedge clk) begin
        #3;
        if (rst_n) begin
            check("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("bundle", dut_bundle(), exp_q[0]);
                if (flush) exp_q.delete();
                else if (out_ready) void'(exp_q.pop_front());
            end else begin
                check("idle_pc_out", pc_out, RESET_PC);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t zero_b;
        rst_n = 1'b0; in_valid = 1'b0; instr = 32'd0; pc_in = 32'd0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        zero_b = '0;
        zero_b.pc = RESET_PC;
        check("reset_bundle", dut_bundle(), zero_b);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        directed(32'h002081B3, 32'h0000_0000, 5'd1,  32'h0000_0000, 1'b1, 1'b0, {5'd1, 5'd2, 5'd3},  4'b1000, 4'b1111);
        directed(32'h40335293, 32'h0000_0004, 5'd8,  32'h0000_0003, 1'b1, 1'b0, {5'd6, 5'd3, 5'd5},  4'b1100, 4'b1111);
        directed(32'h60335293, 32'h0000_0008, 5'd0,  32'h0000_0000, 1'b0, 1'b1, {5'd6, 5'd3, 5'd5},  4'b0000, 4'b1011);
        directed(32'hFE20FEE3, 32'h0000_0100, 5'd16, 32'hFFFF_FFFC, 1'b1, 1'b0, {5'd1, 5'd2, 5'd29}, 4'b0001, 4'b1111);
        directed(32'h123453B7, 32'h0000_0200, 5'd18, 32'h0001_2345, 1'b1, 1'b0, {5'd8, 5'd3, 5'd7},  4'b1000, 4'b1011);
        directed(32'h00001397, 32'h0000_0300, 5'd1,  32'h0000_1000, 1'b1, 1'b0, {5'd0, 5'd0, 5'd7},  4'b1110, 4'b1111);

        // Backpressure: held bundle must stay put, then next loads on the release edge
        cycle(1'b1, 32'h002081B3, 32'h0000_0400, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 32'h40335293, 32'h0000_0404, 1'b0, 1'b0);
        cycle(1'b1, 32'h40335293, 32'h0000_0404, 1'b1, 1'b0);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Flush with a held bundle and a valid incoming one, with and without out_ready
        cycle(1'b1, 32'hFE20FEE3, 32'h0000_0500, 1'b0, 1'b0);
        cycle(1'b1, 32'h123453B7, 32'h0000_0504, 1'b0, 1'b1);
        cycle(1'b1, 32'h00001397, 32'h0000_0508, 1'b0, 1'b0);
        cycle(1'b1, 32'h002081B3, 32'h0000_050C, 1'b1, 1'b1);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Asynchronous reset while a bundle is held
        cycle(1'b1, 32'h002081B3, 32'h0000_0600, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", out_valid, 1'b0);
        check("async_reset_pc_out", pc_out, RESET_PC);
        exp_q.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        repeat (3) cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
